// File: rtl/rv32_instr_encoder.sv
// RV32I field-to-word encoder: packs decoded instruction fields into a legal 32-bit word
// through a two-stage elastic valid/ready pipeline, counting issued and unencodable words.
package rv32_instr_encoder_pkg;
    typedef enum logic [5:0] {
        RV32_UNKNOWN, RV32_LUI, RV32_AUIPC, RV32_JAL, RV32_JALR,
        RV32_BEQ, RV32_BNE, RV32_BLT, RV32_BGE, RV32_BLTU, RV32_BGEU,
        RV32_LB, RV32_LH, RV32_LW, RV32_LBU, RV32_LHU,
        RV32_SB, RV32_SH, RV32_SW,
        RV32_ADDI, RV32_SLTI, RV32_SLTIU, RV32_XORI, RV32_ORI, RV32_ANDI,
        RV32_SLLI, RV32_SRLI, RV32_SRAI,
        RV32_ADD, RV32_SUB, RV32_SLL, RV32_SLT, RV32_SLTU, RV32_XOR,
        RV32_SRL, RV32_SRA, RV32_OR, RV32_AND,
        RV32_FENCE, RV32_FENCEI, RV32_ECALL, RV32_EBREAK,
        RV32_CSRRW, RV32_CSRRS, RV32_CSRRC, RV32_CSRRWI, RV32_CSRRSI, RV32_CSRRCI
    } rv32_opcode_enum_t;
    typedef logic [4:0] rv_register_t;
endpackage

module rv32_instr_encoder
    import rv32_instr_encoder_pkg::*;
#(
    parameter int          CNT_W        = 16,
    parameter logic [31:0] ILLEGAL_WORD = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  rv32_opcode_enum_t in_opcode_i,
    input  rv_register_t      in_rs1_i,
    input  rv_register_t      in_rs2_i,
    input  rv_register_t      in_rd_i,
    input  logic [31:0]       in_imm_i,
    input  logic [4:0]        in_shamt_i,
    input  logic [11:0]       in_csr_i,
    input  logic [4:0]        in_zimm_i,
    input  logic [3:0]        in_fence_pred_i,
    input  logic [3:0]        in_fence_succ_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       out_instr_o,
    output logic              out_err_o,
    output logic [31:0]       out_instr_cnt_o,
    output logic [CNT_W-1:0]  out_err_cnt_o
);
    typedef enum logic [3:0] {
        FMT_BAD, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J,
        FMT_CSR, FMT_CSRI, FMT_FENCE, FMT_FIXED
    } fmt_e;

    logic              s1_valid_q, s2_valid_q;
    rv32_opcode_enum_t s1_op_q;
    rv_register_t      s1_rs1_q, s1_rs2_q, s1_rd_q;
    logic [31:0]       s1_imm_q;
    logic [4:0]        s1_shamt_q, s1_zimm_q;
    logic [11:0]       s1_csr_q;
    logic [3:0]        s1_pred_q, s1_succ_q;
    logic [31:0]       s2_word_q;
    logic              s2_err_q;
    logic [31:0]       instr_cnt_q, instr_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic s2_adv, s1_adv, in_fire, out_fire;
    assign s2_adv     = !s2_valid_q || out_ready_i;
    assign s1_adv     = !s1_valid_q || s2_adv;
    assign in_ready_o = s1_adv && !flush_i;
    assign in_fire    = in_valid_i && in_ready_o;
    assign out_fire   = s2_valid_q && out_ready_i;

    fmt_e        fmt;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] fixed_word;

    always_comb begin
        fmt = FMT_BAD; opc = 7'b0; f3 = 3'b0; f7 = 7'b0; fixed_word = ILLEGAL_WORD;
        case (s1_op_q)
            RV32_LUI:    begin fmt = FMT_U; opc = 7'b0110111; end
            RV32_AUIPC:  begin fmt = FMT_U; opc = 7'b0010111; end
            RV32_JAL:    begin fmt = FMT_J; opc = 7'b1101111; end
            RV32_JALR:   begin fmt = FMT_I; opc = 7'b1100111; f3 = 3'b000; end
            RV32_BEQ:    begin fmt = FMT_B; opc = 7'b1100011; f3 = 3'b000; end
            RV32_BNE:    begin fmt = FMT_B; opc = 7'b1100011; f3 = 3'b001; end
            RV32_BLT:    begin fmt = FMT_B; opc = 7'b1100011; f3 = 3'b100; end
            RV32_BGE:    begin fmt = FMT_B; opc = 7'b1100011; f3 = 3'b101; end
            RV32_BLTU:   begin fmt = FMT_B; opc = 7'b1100011; f3 = 3'b110; end
            RV32_BGEU:   begin fmt = FMT_B; opc = 7'b1100011; f3 = 3'b111; end
            RV32_LB:     begin fmt = FMT_I; opc = 7'b0000011; f3 = 3'b000; end
            RV32_LH:     begin fmt = FMT_I; opc = 7'b0000011; f3 = 3'b001; end
            RV32_LW:     begin fmt = FMT_I; opc = 7'b0000011; f3 = 3'b010; end
            RV32_LBU:    begin fmt = FMT_I; opc = 7'b0000011; f3 = 3'b100; end
            RV32_LHU:    begin fmt = FMT_I; opc = 7'b0000011; f3 = 3'b101; end
            RV32_SB:     begin fmt = FMT_S; opc = 7'b0100011; f3 = 3'b000; end
            RV32_SH:     begin fmt = FMT_S; opc = 7'b0100011; f3 = 3'b001; end
            RV32_SW:     begin fmt = FMT_S; opc = 7'b0100011; f3 = 3'b010; end
            RV32_ADDI:   begin fmt = FMT_I; opc = 7'b0010011; f3 = 3'b000; end
            RV32_SLTI:   begin fmt = FMT_I; opc = 7'b0010011; f3 = 3'b010; end
            RV32_SLTIU:  begin fmt = FMT_I; opc = 7'b0010011; f3 = 3'b011; end
            RV32_XORI:   begin fmt = FMT_I; opc = 7'b0010011; f3 = 3'b100; end
            RV32_ORI:    begin fmt = FMT_I; opc = 7'b0010011; f3 = 3'b110; end
            RV32_ANDI:   begin fmt = FMT_I; opc = 7'b0010011; f3 = 3'b111; end
            RV32_SLLI:   begin fmt = FMT_SH; opc = 7'b0010011; f3 = 3'b001; end
            RV32_SRLI:   begin fmt = FMT_SH; opc = 7'b0010011; f3 = 3'b101; end
            RV32_SRAI:   begin fmt = FMT_SH; opc = 7'b0010011; f3 = 3'b101; f7 = 7'b0100000; end
            RV32_ADD:    begin fmt = FMT_R; opc = 7'b0110011; f3 = 3'b000; end
            RV32_SUB:    begin fmt = FMT_R; opc = 7'b0110011; f3 = 3'b000; f7 = 7'b0100000; end
            RV32_SLL:    begin fmt = FMT_R; opc = 7'b0110011; f3 = 3'b001; end
            RV32_SLT:    begin fmt = FMT_R; opc = 7'b0110011; f3 = 3'b010; end
            RV32_SLTU:   begin fmt = FMT_R; opc = 7'b0110011; f3 = 3'b011; end
            RV32_XOR:    begin fmt = FMT_R; opc = 7'b0110011; f3 = 3'b100; end
            RV32_SRL:    begin fmt = FMT_R; opc = 7'b0110011; f3 = 3'b101; end
            RV32_SRA:    begin fmt = FMT_R; opc = 7'b0110011; f3 = 3'b101; f7 = 7'b0100000; end
            RV32_OR:     begin fmt = FMT_R; opc = 7'b0110011; f3 = 3'b110; end
            RV32_AND:    begin fmt = FMT_R; opc = 7'b0110011; f3 = 3'b111; end
            RV32_FENCE:  begin fmt = FMT_FENCE; opc = 7'b0001111; end
            RV32_FENCEI: begin fmt = FMT_FIXED; fixed_word = 32'h0000_100F; end
            RV32_ECALL:  begin fmt = FMT_FIXED; fixed_word = 32'h0000_0073; end
            RV32_EBREAK: begin fmt = FMT_FIXED; fixed_word = 32'h0010_0073; end
            RV32_CSRRW:  begin fmt = FMT_CSR; opc = 7'b1110011; f3 = 3'b001; end
            RV32_CSRRS:  begin fmt = FMT_CSR; opc = 7'b1110011; f3 = 3'b010; end
            RV32_CSRRC:  begin fmt = FMT_CSR; opc = 7'b1110011; f3 = 3'b011; end
            RV32_CSRRWI: begin fmt = FMT_CSRI; opc = 7'b1110011; f3 = 3'b101; end
            RV32_CSRRSI: begin fmt = FMT_CSRI; opc = 7'b1110011; f3 = 3'b110; end
            RV32_CSRRCI: begin fmt = FMT_CSRI; opc = 7'b1110011; f3 = 3'b111; end
            default:     fmt = FMT_BAD;
        endcase
    end

    // An immediate fits a format when every bit above its sign bit matches the sign bit.
    logic        i_ok, b_ok, j_ok, u_ok;
    logic [31:0] enc_word;
    logic        enc_err;
    assign i_ok = (&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]);
    assign b_ok = ((&s1_imm_q[31:12]) || !(|s1_imm_q[31:12])) && !s1_imm_q[0];
    assign j_ok = ((&s1_imm_q[31:20]) || !(|s1_imm_q[31:20])) && !s1_imm_q[0];
    assign u_ok = !(|s1_imm_q[11:0]);

    always_comb begin
        enc_word = ILLEGAL_WORD;
        enc_err  = 1'b1;
        case (fmt)
            FMT_R:     begin enc_err = 1'b0; enc_word = {f7, s1_rs2_q, s1_rs1_q, f3, s1_rd_q, opc}; end
            FMT_SH:    begin enc_err = 1'b0; enc_word = {f7, s1_shamt_q, s1_rs1_q, f3, s1_rd_q, opc}; end
            FMT_I:     if (i_ok) begin
                           enc_err = 1'b0; enc_word = {s1_imm_q[11:0], s1_rs1_q, f3, s1_rd_q, opc};
                       end
            FMT_S:     if (i_ok) begin
                           enc_err  = 1'b0;
                           enc_word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, f3, s1_imm_q[4:0], opc};
                       end
            FMT_B:     if (b_ok) begin
                           enc_err  = 1'b0;
                           enc_word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, f3,
                                       s1_imm_q[4:1], s1_imm_q[11], opc};
                       end
            FMT_U:     if (u_ok) begin
                           enc_err = 1'b0; enc_word = {s1_imm_q[31:12], s1_rd_q, opc};
                       end
            FMT_J:     if (j_ok) begin
                           enc_err  = 1'b0;
                           enc_word = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12], s1_rd_q, opc};
                       end
            FMT_CSR:   begin enc_err = 1'b0; enc_word = {s1_csr_q, s1_rs1_q, f3, s1_rd_q, opc}; end
            FMT_CSRI:  begin enc_err = 1'b0; enc_word = {s1_csr_q, s1_zimm_q, f3, s1_rd_q, opc}; end
            FMT_FENCE: begin enc_err = 1'b0; enc_word = {4'b0, s1_pred_q, s1_succ_q, 5'b0, 3'b000, 5'b0, opc}; end
            FMT_FIXED: begin enc_err = 1'b0; enc_word = fixed_word; end
            default:   enc_err = 1'b1;
        endcase
    end

    always_comb begin
        instr_cnt_d = instr_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (out_fire) begin
            instr_cnt_d = instr_cnt_q + 32'd1;
            if (s2_err_q && (err_cnt_q != {CNT_W{1'b1}})) err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s1_op_q     <= RV32_UNKNOWN;
            s1_rs1_q    <= '0;
            s1_rs2_q    <= '0;
            s1_rd_q     <= '0;
            s1_imm_q    <= '0;
            s1_shamt_q  <= '0;
            s1_zimm_q   <= '0;
            s1_csr_q    <= '0;
            s1_pred_q   <= '0;
            s1_succ_q   <= '0;
            s2_word_q   <= '0;
            s2_err_q    <= 1'b0;
            instr_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            err_cnt_q   <= err_cnt_d;
            if (flush_i)     s1_valid_q <= 1'b0;
            else if (s1_adv) s1_valid_q <= in_valid_i;
            if (flush_i)     s2_valid_q <= 1'b0;
            else if (s2_adv) s2_valid_q <= s1_valid_q;
            if (in_fire) begin
                s1_op_q    <= in_opcode_i;
                s1_rs1_q   <= in_rs1_i;
                s1_rs2_q   <= in_rs2_i;
                s1_rd_q    <= in_rd_i;
                s1_imm_q   <= in_imm_i;
                s1_shamt_q <= in_shamt_i;
                s1_zimm_q  <= in_zimm_i;
                s1_csr_q   <= in_csr_i;
                s1_pred_q  <= in_fence_pred_i;
                s1_succ_q  <= in_fence_succ_i;
            end
            // Word registers only change when a new word moves in, so a stalled output holds steady.
            if (s2_adv && s1_valid_q && !flush_i) begin
                s2_word_q <= enc_word;
                s2_err_q  <= enc_err;
            end
        end
    end

    assign out_valid_o     = s2_valid_q;
    assign out_instr_o     = s2_word_q;
    assign out_err_o       = s2_err_q;
    assign out_instr_cnt_o = instr_cnt_q;
    assign out_err_cnt_o   = err_cnt_q;
endmodule
